vga_timing: RTL
===============

# vga_timing

Free-running VGA raster timing generator for 800×600 @ 60 Hz on the 40 MHz pixel clock. It sits at the head of the `top_vga` pipeline and supplies pixel coordinates, sync and blanking to the downstream draw stages, which ultimately drive the board's `Hsync`/`Vsync`/colour pins. All outputs are registered and mutually aligned, so every downstream stage sees a coherent (hcount, vcount, sync, blank) tuple per cycle.

## Interface
Parameters:
- `H_ACTIVE`, default 800: visible pixels per line.
- `H_FP`, default 40: horizontal front porch, in pixels.
- `H_SYNC`, default 128: hsync pulse width, in pixels.
- `H_BP`, default 88: horizontal back porch, in pixels.
- `V_ACTIVE`, default 600: visible lines per frame.
- `V_FP`, default 1: vertical front porch, in lines.
- `V_SYNC`, default 4: vsync pulse width, in lines.
- `V_BP`, default 23: vertical back porch, in lines.
- `CNT_W`, default 11: width of the coordinate counters; must hold H_TOTAL−1 and V_TOTAL−1.

Ports:
- `clk`  in  1  pixel clock (40 MHz). Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `hcount`  out  CNT_W  horizontal position, 0..H_TOTAL−1.
- `vcount`  out  CNT_W  vertical position, 0..V_TOTAL−1.
- `hsync`  out  1  horizontal sync, active-high.
- `vsync`  out  1  vertical sync, active-high.
- `hblnk`  out  1  horizontal blanking.
- `vblnk`  out  1  vertical blanking.
- `frame`  out  16  frame counter. Present only with `VGA_TIMING_FRAME_CNT_EN` (see Configuration).

## Operation
- Derived totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 1056; V_TOTAL = 628.
- Horizontal counter: increments every cycle and wraps from H_TOTAL−1 to 0.
- Vertical counter: increments only when hcount wraps; wraps from V_TOTAL−1 to 0 on the same cycle hcount wraps from 1055.
- Decode:
  - `hblnk` = hcount ≥ H_ACTIVE.
  - `hsync` = H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 840..967.
  - `vblnk` = vcount ≥ V_ACTIVE.
  - `vsync` = 600+V_FP ≤ vcount < 600+V_FP+V_SYNC, i.e. 601..604.
- Alignment: decode is computed from the next-count values and registered, so all outputs in a given cycle describe the same (hcount, vcount) coordinate. Zero relative skew between outputs.
- Sync pulses are gated by count only. Blanking does not gate sync.
- Reset:
  - Forces hcount = 0, vcount = 0, hsync = 0, vsync = 0, hblnk = 0, vblnk = 0, frame = 0.
  - Reset asserted mid-frame takes effect on the next clk edge, discarding the current position. Counting resumes from (0,0) on the first edge after `rst` deasserts.

## Timing
- Outputs change only on the rising edge of `clk`. No combinational path from inputs to outputs.
- First cycle after reset release: outputs reflect (0,0). The next edge gives hcount = 1.
- Line period: 1056 cycles. Frame period: 1056 × 628 = 663168 cycles.
- hsync: high for exactly 128 consecutive cycles per line. vsync: high for exactly 4 × 1056 = 4224 consecutive cycles per frame.
- hblnk and vblnk: each rises and falls on the same edge as the count value that crosses the relevant boundary.

## Configuration
- Macro: `VGA_TIMING_FRAME_CNT_EN`.
- Defined:
  - A 16-bit `frame` output port exists.
  - It increments by 1 on the edge where (hcount, vcount) wraps to (0,0).
  - It wraps 0xFFFF → 0x0000 and resets to 0.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Hold `rst` = 1 for 5 cycles with counting already in progress → all outputs read 0 on the edge after assertion. After release, hcount steps 0,1,2 on successive edges.
- Run one line → hcount 1055 is followed by hcount 0 with vcount 0→1. hblnk rises at hcount 800. hsync is high for hcount 840..967 only (128 cycles).
- Run a full frame → (1055,627) is followed by (0,0). vblnk is high for vcount 600..627. vsync is high for vcount 601..604 only. Frame length is 663168 cycles.
- Assert `rst` for one cycle at (500,300) → next outputs are (0,0) with syncs low. The following frame boundary occurs 663168 cycles after release.
- Each cycle, check that the output tuple matches a reference model computed from the observed hcount/vcount → zero mismatches over 2 frames.
- With `VGA_TIMING_FRAME_CNT_EN` defined, run 3 frames → frame = 3, incrementing exactly at each (0,0). Preload via forced wrap at 0xFFFF → next value 0x0000.

Source files
------------

// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster timing generator (800x600 @ 60 Hz on a
// 40 MHz pixel clock with the default parameters).
//
// Ports:
//   clk     in   1      pixel clock, single clock domain
//   rst     in   1      synchronous, active-high reset
//   frame   out  16     frame counter (only with VGA_TIMING_FRAME_CNT_EN)
//   hcount  out  CNT_W  horizontal position, 0..H_TOTAL-1
//   vcount  out  CNT_W  vertical position, 0..V_TOTAL-1
//   hsync   out  1      horizontal sync, active-high
//   vsync   out  1      vertical sync, active-high
//   hblnk   out  1      horizontal blanking
//   vblnk   out  1      vertical blanking
//
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame
// counter output, which increments on the edge where (hcount, vcount) wraps
// to (0,0). Without the macro the port and its register are absent.
//
// All outputs are registered. Sync/blank are decoded from the next-count
// values so every output in a cycle describes the same coordinate.

module vga_timing #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter int unsigned CNT_W    = 11
) (
    input  logic             clk,
    input  logic             rst,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [15:0]      frame,
`endif
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BLNK_BEG = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_BLNK_BEG = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             h_wrap, v_wrap;

    // Next-count computation and decode of the next coordinate.
    always_comb begin
        h_wrap   = (hcount_q == H_LAST);
        v_wrap   = (vcount_q == V_LAST);
        hcount_d = h_wrap ? '0 : hcount_q + CNT_W'(1);
        vcount_d = vcount_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? '0 : vcount_q + CNT_W'(1);
        end

        hblnk_d = (hcount_d >= H_BLNK_BEG);
        hsync_d = (hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END);
        vblnk_d = (vcount_d >= V_BLNK_BEG);
        vsync_d = (vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_q, frame_d;

    // Advance on the same edge the raster returns to (0,0); wraps naturally.
    always_comb begin
        frame_d = frame_q;
        if (h_wrap && v_wrap) begin
            frame_d = frame_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame = frame_q;
`endif

    assign hcount = hcount_q;
    assign vcount = vcount_q;
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;
    assign hblnk  = hblnk_q;
    assign vblnk  = vblnk_q;

endmodule
